// File: rtl/cpu_consts.sv
// cpu_consts: shared RV64I constants (XLEN and B-type funct3 encodings)
package cpu_consts;
    localparam int XLEN = 64;
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;
endpackage

// File: rtl/branch_comparator.sv
// branch_comparator: equality, signed and unsigned less-than of two XLEN operands
module branch_comparator
    import cpu_consts::*;
(
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    output logic            eq_o,
    output logic            lt_s_o,
    output logic            lt_u_o
);
    assign eq_o   = opr_a_i == opr_b_i;
    assign lt_s_o = $signed(opr_a_i) < $signed(opr_b_i);
    assign lt_u_o = opr_a_i < opr_b_i;
endmodule

// File: rtl/branch_control.sv
// branch_control: B-type funct3 decode into taken/illegal flags plus registered copies
module branch_control
    import cpu_consts::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  logic            is_b_type_i,
    input  logic [2:0]      instr_funct3_i,
    output logic            branch_taken_o,
    output logic            branch_taken_q_o,
    output logic            illegal_funct3_o,
    output logic            illegal_funct3_q_o
);
    logic eq, lt_s, lt_u;
    logic taken_d, illegal_d, taken_q, illegal_q;

    branch_comparator u_cmp (
        .opr_a_i (opr_a_i),
        .opr_b_i (opr_b_i),
        .eq_o    (eq),
        .lt_s_o  (lt_s),
        .lt_u_o  (lt_u)
    );

    // funct3 decode; non-branches and reserved encodings are never taken
    always_comb begin
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        if (is_b_type_i) begin
            case (instr_funct3_i)
                BEQ:     taken_d = eq;
                BNE:     taken_d = !eq;
                BLT:     taken_d = lt_s;
                BGE:     taken_d = !lt_s;
                BLTU:    taken_d = lt_u;
                BGEU:    taken_d = !lt_u;
                default: illegal_d = 1'b1;
            endcase
        end
    end

    // one-cycle registered copies, cleared immediately by reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign branch_taken_o     = taken_d;
    assign illegal_funct3_o   = illegal_d;
    assign branch_taken_q_o   = taken_q;
    assign illegal_funct3_q_o = illegal_q;
endmodule

// File: tb/tb_branch_control.sv
// tb_branch_control: scoreboard bench for branch_control combinational and registered outputs
module tb_branch_control;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic        bt = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic        tk, tk_q, il, il_q;
    int          checks = 0, failures = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bt;
        logic [2:0]  f3;
        logic        tk;
        logic        il;
        string       tag;
    } vec_t;

    vec_t        vecs[$];
    logic [1:0]  cq[$], rq[$];
    string       tq[$], rtq[$];

    branch_control dut (
        .clk                (clk),
        .resetn             (resetn),
        .opr_a_i            (a),
        .opr_b_i            (b),
        .is_b_type_i        (bt),
        .instr_funct3_i     (f3),
        .branch_taken_o     (tk),
        .branch_taken_q_o   (tk_q),
        .illegal_funct3_o   (il),
        .illegal_funct3_q_o (il_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model(input logic [63:0] x, input logic [63:0] y,
                                         input logic v, input logic [2:0] f);
        logic ls, lu, e;
        if (!v) return 2'b00;
        e  = x == y;
        lu = x < y;
        ls = (x[63] ^ y[63]) ? x[63] : lu;
        case (f)
            3'b000: return {e, 1'b0};
            3'b001: return {!e, 1'b0};
            3'b100: return {ls, 1'b0};
            3'b101: return {!ls, 1'b0};
            3'b110: return {lu, 1'b0};
            3'b111: return {!lu, 1'b0};
            default: return 2'b01;
        endcase
    endfunction

    task automatic add(input string tag, input logic [63:0] x, input logic [63:0] y,
                       input logic v, input logic [2:0] f, input logic t, input logic i);
        vec_t e;
        e.a = x; e.b = y; e.bt = v; e.f3 = f; e.tk = t; e.il = i; e.tag = tag;
        vecs.push_back(e);
    endtask

    task automatic run_vec(input vec_t e);
        logic [1:0] got;
        @(negedge clk);
        a = e.a; b = e.b; bt = e.bt; f3 = e.f3;
        cq.push_back({e.tk, e.il}); tq.push_back(e.tag);
        rq.push_back({e.tk, e.il}); rtq.push_back(e.tag);
        #1;
        got = {tk, il};
        check({tq.pop_front(), "_comb"}, got, cq.pop_front());
        @(posedge clk);
        #1;
        got = {tk_q, il_q};
        check({rtq.pop_front(), "_reg"}, got, rq.pop_front());
    endtask

    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M5   = 64'hFFFF_FFFF_FFFF_FFFB;

    initial begin
        logic [63:0] x, y;
        logic        v;
        logic [2:0]  f;
        logic [1:0]  m;
        add("beq_eq",    64'h1234, 64'h1234, 1, 3'b000, 1, 0);
        add("beq_ne",    64'h1234, 64'h1235, 1, 3'b000, 0, 0);
        add("beq_msb",   64'h0,    MSB,      1, 3'b000, 0, 0);
        add("bne_eq",    64'h1234, 64'h1234, 1, 3'b001, 0, 0);
        add("bne_ne",    64'h1234, 64'h1235, 1, 3'b001, 1, 0);
        add("bne_msb",   64'h0,    MSB,      1, 3'b001, 1, 0);
        add("blt_m1_1",  ONES,     64'h1,    1, 3'b100, 1, 0);
        add("bge_m1_1",  ONES,     64'h1,    1, 3'b101, 0, 0);
        add("blt_max",   MAXP,     MSB,      1, 3'b100, 0, 0);
        add("bge_max",   MAXP,     MSB,      1, 3'b101, 1, 0);
        add("blt_m5",    M5,       M5,       1, 3'b100, 0, 0);
        add("bge_m5",    M5,       M5,       1, 3'b101, 1, 0);
        add("bltu_1_f",  64'h1,    ONES,     1, 3'b110, 1, 0);
        add("bgeu_1_f",  64'h1,    ONES,     1, 3'b111, 0, 0);
        add("bltu_msb",  MSB,      MAXP,     1, 3'b110, 0, 0);
        add("bgeu_msb",  MSB,      MAXP,     1, 3'b111, 1, 0);
        add("bltu_0",    64'h0,    64'h0,    1, 3'b110, 0, 0);
        add("bgeu_0",    64'h0,    64'h0,    1, 3'b111, 1, 0);
        add("nob_beq",   64'h55,   64'h55,   0, 3'b000, 0, 0);
        add("ill_010",   64'h55,   64'h55,   1, 3'b010, 0, 1);
        add("ill_011",   64'h1,    64'h2,    1, 3'b011, 0, 1);
        add("nob_011",   64'h1,    64'h2,    0, 3'b011, 0, 0);
        for (int i = 0; i < 40; i++) begin
            x = {$urandom, $urandom};
            y = (i % 5 == 0) ? x : {$urandom, $urandom};
            v = (i % 7) != 0;
            f = 3'($urandom_range(0, 7));
            m = model(x, y, v, f);
            add($sformatf("rnd%0d", i), x, y, v, f, m[1], m[0]);
        end

        #2;
        check("rst_tk_q", tk_q, 0);
        check("rst_il_q", il_q, 0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // illegal encoding then taken BEQ, then async reset mid-cycle
        run_vec(vecs[19]);
        check("ill_q_set", il_q, 1);
        @(negedge clk);
        a = 64'h1234; b = 64'h1234; bt = 1'b1; f3 = 3'b000;
        #1;
        check("pre_edge_tk_q", tk_q, 0);
        check("pre_edge_il_q", il_q, 1);
        @(posedge clk);
        #1;
        check("edge_tk_q", tk_q, 1);
        check("edge_il_q", il_q, 0);
        #2;
        resetn = 1'b0;
        #1;
        check("async_tk_q", tk_q, 0);
        check("async_il_q", il_q, 0);
        check("async_tk_comb", tk, 1);
        #1;
        resetn = 1'b1;
        #1;
        check("hold_tk_q", tk_q, 0);
        @(posedge clk);
        #1;
        check("recover_tk_q", tk_q, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
